// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : In-order posted-write queue between the execute stage and the
//            data-memory write port. Retires one store per cycle and forwards
//            the youngest pending store data to in-flight loads.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_address,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       mem_stall,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_write_data,
    output logic                       mem_write_enable,
    input  logic [ADDR_W-1:0]          ld_address,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // Handshake and drain qualifiers; all derived from registered state plus
    // the live stall/valid inputs, so there is no in_* -> mem_* bypass.
    assign w_empty          = (r_count == '0);
    assign in_ready         = (r_count != C_FULL);
    assign w_push           = in_valid && in_ready;
    assign mem_write_enable = !w_empty && !mem_stall;
    assign w_pop            = mem_write_enable;

    assign empty          = w_empty;
    assign count          = r_count;
    assign mem_address    = w_empty ? '0 : r_addr[r_head];
    assign mem_write_data = w_empty ? '0 : r_data[r_head];

    // Queue storage, pointers and occupancy. Push and pop never target the
    // same slot in one cycle: pop needs a non-empty queue, push a non-full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_tail]  <= in_address;
                r_data[r_tail]  <= in_data;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Load forwarding: walk entries oldest to youngest so the last match seen
    // (the one nearest the tail) wins. The head being retired this cycle is
    // still valid here; an entry pushed this cycle is not yet visible.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PTR_W-1:0] idx;
            idx = r_head + PTR_W'(k);
            if (r_valid[idx] && (r_addr[idx] == ld_address)) begin
                ld_hit  = 1'b1;
                ld_data = r_data[idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Directed self-checking bench for store_buffer (DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_address;
    logic [DATA_W-1:0] in_data;
    logic              mem_stall;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] ld_address;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic [2:0]        count;
    logic              empty;

    int checks;
    int passed;

    store_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_address       (in_address),
        .in_data          (in_data),
        .mem_stall        (mem_stall),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .ld_address       (ld_address),
        .ld_hit           (ld_hit),
        .ld_data          (ld_data),
        .count            (count),
        .empty            (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after a falling edge; outputs are sampled #1 later,
    // well away from the rising edge.
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_address = '0; in_data = '0;
        mem_stall = 1'b0; ld_address = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, empty, mem_write_enable, ld_hit} !== 4'b1100 || count !== 3'd0)
            $display("FAIL reset_flags ready/empty/we/hit=%b count=%0d required 1100 count=0",
                     {in_ready, empty, mem_write_enable, ld_hit}, count);
        else passed++;
        checks++;
        if (mem_address !== '0 || mem_write_data !== '0 || ld_data !== '0)
            $display("FAIL reset_buses addr=%h data=%h ld=%h required all zero",
                     mem_address, mem_write_data, ld_data);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_address = 32'd55; in_data = 32'h56;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (mem_address !== 32'd55 || mem_write_data !== 32'h56 || mem_write_enable !== 1'b1)
            $display("FAIL single_bus addr=%0d data=%h we=%b required 55 56 1",
                     mem_address, mem_write_data, mem_write_enable);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (empty !== 1'b1 || count !== 3'd0 || mem_write_enable !== 1'b0)
            $display("FAIL single_drain empty=%b count=%0d we=%b required 1 0 0",
                     empty, count, mem_write_enable);
        else passed++;
    endtask

    task automatic test_stall_order();
        logic [31:0] addrs [4];
        logic [31:0] datas [4];
        addrs = '{32'd55, 32'd66, 32'd77, 32'd88};
        datas = '{32'h56, 32'h36, 32'h11, 32'h22};
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_address = addrs[i]; in_data = datas[i];
        end
        // fifth store offered while full
        @(negedge clk);
        in_address = 32'd99; in_data = 32'h99;
        #1;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0 || mem_write_enable !== 1'b0)
            $display("FAIL stall_full count=%0d ready=%b we=%b required 4 0 0",
                     count, in_ready, mem_write_enable);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd4 || mem_address !== 32'd55)
            $display("FAIL stall_refused count=%0d head=%0d required 4 55", count, mem_address);
        else passed++;
        mem_stall = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_write_enable !== 1'b1 || mem_address !== addrs[i] || mem_write_data !== datas[i])
                $display("FAIL stall_order[%0d] we=%b addr=%0d data=%h required 1 %0d %h",
                         i, mem_write_enable, mem_address, mem_write_data, addrs[i], datas[i]);
            else passed++;
            @(negedge clk); #1;
            if (i == 0) begin
                checks++;
                if (in_ready !== 1'b1)
                    $display("FAIL stall_ready_after_retire ready=%b required 1", in_ready);
                else passed++;
            end
        end
        checks++;
        if (empty !== 1'b1 || mem_write_enable !== 1'b0)
            $display("FAIL stall_drained empty=%b we=%b required 1 0", empty, mem_write_enable);
        else passed++;
    endtask

    task automatic test_simultaneous();
        mem_stall = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            in_valid = 1'b1; in_address = 32'(i); in_data = 32'(i * 16);
            @(negedge clk);
        end
        mem_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_address = 32'(i + 3); in_data = 32'((i + 3) * 16);
            #1;
            checks++;
            if (count !== 3'd2 || mem_write_enable !== 1'b1 ||
                mem_address !== 32'(i + 1) || mem_write_data !== 32'((i + 1) * 16))
                $display("FAIL simul[%0d] count=%0d we=%b addr=%0d data=%h required 2 1 %0d %h",
                         i, count, mem_write_enable, mem_address, mem_write_data, i + 1, (i + 1) * 16);
            else passed++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 7; i <= 8; i++) begin
            #1;
            checks++;
            if (mem_write_enable !== 1'b1 || mem_address !== 32'(i))
                $display("FAIL simul_tail we=%b addr=%0d required 1 %0d", mem_write_enable, mem_address, i);
            else passed++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (empty !== 1'b1)
            $display("FAIL simul_empty empty=%b required 1", empty);
        else passed++;
    endtask

    task automatic test_forward_and_reset();
        mem_stall = 1'b1;
        in_valid = 1'b1; in_address = 32'd55; in_data = 32'h56;
        @(negedge clk);
        in_address = 32'd55; in_data = 32'h99; ld_address = 32'd55;
        #1;
        checks++;
        if (ld_hit !== 1'b1 || ld_data !== 32'h56)
            $display("FAIL fwd_push_invisible hit=%b data=%h required 1 56", ld_hit, ld_data);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (ld_hit !== 1'b1 || ld_data !== 32'h99)
            $display("FAIL fwd_youngest hit=%b data=%h required 1 99", ld_hit, ld_data);
        else passed++;
        ld_address = 32'd66;
        #1;
        checks++;
        if (ld_hit !== 1'b0 || ld_data !== 32'h0)
            $display("FAIL fwd_miss hit=%b data=%h required 0 0", ld_hit, ld_data);
        else passed++;
        // third entry, then asynchronous reset between edges
        in_valid = 1'b1; in_address = 32'd77; in_data = 32'h11;
        @(negedge clk);
        in_valid = 1'b0; ld_address = 32'd55;
        #1;
        checks++;
        if (count !== 3'd3)
            $display("FAIL rst_mid_prefill count=%0d required 3", count);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || ld_hit !== 1'b0 || in_ready !== 1'b1 ||
            mem_address !== '0 || mem_write_data !== '0 || ld_data !== '0)
            $display("FAIL rst_mid_clear count=%0d empty=%b hit=%b ready=%b addr=%h required 0 1 0 1 0",
                     count, empty, ld_hit, in_ready, mem_address);
        else passed++;
        #1 rst_n = 1'b1;
        @(negedge clk);
        mem_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_write_enable !== 1'b0)
                $display("FAIL rst_mid_nowrite[%0d] we=%b required 0", i, mem_write_enable);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        int pushed;
        int retired;
        int cyc;
        pushed = 0; retired = 0; cyc = 0;
        while (retired < 10 && cyc < 80) begin
            mem_stall  = cyc[0];
            in_valid   = (pushed < 10);
            in_address = 32'(100 + pushed);
            in_data    = 32'(200 + pushed);
            #1;
            if (mem_write_enable) begin
                checks++;
                if (mem_address !== 32'(100 + retired) || mem_write_data !== 32'(200 + retired))
                    $display("FAIL wrap_order addr=%0d data=%0d required %0d %0d",
                             mem_address, mem_write_data, 100 + retired, 200 + retired);
                else passed++;
                retired++;
            end
            checks++;
            if (count > 3'd4)
                $display("FAIL wrap_count count=%0d required <=4", count);
            else passed++;
            if (in_valid && in_ready) pushed++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (retired !== 10)
            $display("FAIL wrap_total retired=%0d required 10", retired);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_single();
        test_stall_order();
        test_simultaneous();
        test_forward_and_reset();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
